// File: rtl/aes_ct_serializer.sv
//------------------------------------------------------------------------------
// Module : aes_ct_serializer
// Brief  : Buffers 128-bit ciphertext blocks in a small FIFO and streams them
//          out MSB-byte-first over a valid/ready beat interface.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module aes_ct_serializer #(
    parameter int DATA_W = 128,
    parameter int OUT_W  = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ct_valid,
    input  logic [DATA_W-1:0] ct_in,
    output logic              ct_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam int c_BEATS = DATA_W / OUT_W;
    localparam int c_BW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW    = $clog2(DEPTH + 1);

    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(c_BEATS - 1);
    localparam logic [c_AW-1:0] c_PTR_MAX   = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FILL_MAX  = c_CW'(DEPTH);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_fill;
    logic [DATA_W-1:0] r_shift;
    logic [c_BW-1:0]   r_beat;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_last_beat;
    logic [c_AW-1:0]   w_wr_nxt;
    logic [c_AW-1:0]   w_rd_nxt;

    assign w_full      = (r_fill == c_FILL_MAX);
    assign w_empty     = (r_fill == '0);
    assign w_push      = ct_valid && !w_full;
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign w_accept    = (r_state == S_SHIFT) && out_ready;
    // Refill the shifter either from idle or straight after the final beat,
    // so back-to-back blocks stream without a bubble.
    assign w_pop       = !w_empty && ((r_state == S_EMPTY) || (w_accept && w_last_beat));
    assign w_wr_nxt    = (r_wr_ptr == c_PTR_MAX) ? '0 : r_wr_ptr + c_AW'(1);
    assign w_rd_nxt    = (r_rd_ptr == c_PTR_MAX) ? '0 : r_rd_ptr + c_AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (!w_empty) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_accept && w_last_beat && w_empty) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_SHIFT);
        out_last  = out_valid && w_last_beat;
        out_data  = out_valid ? r_shift[DATA_W-1 -: OUT_W] : '0;
        ct_ready  = !w_full;
        overflow  = r_overflow;
        drop_cnt  = r_drop_cnt;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ct_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_shift    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
                r_shift  <= r_mem[r_rd_ptr];
                r_beat   <= '0;
            end else if (w_accept && !w_last_beat) begin
                r_shift <= r_shift << OUT_W;
                r_beat  <= r_beat + c_BW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_CW'(1);
                2'b01:   r_fill <= r_fill - c_CW'(1);
                default: r_fill <= r_fill;
            endcase
            if (ct_valid && w_full) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire
